// File: rtl/lane_mem_ctrl.sv
// Lane-organised word memory behind a request/response handshake.
// Byte-enabled single-beat writes, linear read bursts, out-of-range beats flagged with rsp_err.
//
// state    | meaning
// IDLE     | ready for a request
// RD_BURST | presenting read beats, cnt_q = beats remaining after this one
// WR_ACK   | presenting the single write acknowledge beat
module lane_mem_ctrl #(
    parameter int LANES  = 4,
    parameter int LANE_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [LEN_W-1:0]          req_len,
    input  logic [LANES*LANE_W-1:0]   req_wdata,
    input  logic [LANES-1:0]          req_be,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [LANES*LANE_W-1:0]   rsp_data,
    output logic                      rsp_last,
    output logic                      rsp_err
);

    localparam int DATA_W = LANES * LANE_W;
    localparam int IDX_W  = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_ACK
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                wr_en;
    logic                cur_in_range;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Shifting instead of comparing against DEPTH stays correct when DEPTH == 2**ADDR_W.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >> IDX_W) == '0;
    endfunction

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    if (req_write) begin
                        wr_en   = in_range(req_addr);
                        state_d = WR_ACK;
                    end else begin
                        cnt_d   = req_len;
                        state_d = RD_BURST;
                    end
                end
            end
            RD_BURST: begin
                if (rsp_ready) begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d  = cnt_q - 1'b1;
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            WR_ACK: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage is deliberately not reset; rst only blocks a write on the same edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_en && !rst && req_be[i]) begin
                mem[req_addr[IDX_W-1:0]][i*LANE_W +: LANE_W] <= req_wdata[i*LANE_W +: LANE_W];
            end
        end
    end

    // No writes occur while a response is pending, so a combinational read holds stable under stall.
    always_comb begin
        cur_in_range = in_range(addr_q);
        req_ready    = (state_q == IDLE);
        rsp_valid    = (state_q != IDLE);
        rsp_last     = (state_q == WR_ACK) || ((state_q == RD_BURST) && (cnt_q == '0));
        rsp_err      = rsp_valid && !cur_in_range;
        rsp_data     = '0;
        if ((state_q == RD_BURST) && cur_in_range) begin
            rsp_data = mem[addr_q[IDX_W-1:0]];
        end
    end

endmodule

// File: tb/tb_lane_mem_ctrl.sv
// Bench for lane_mem_ctrl: transaction-level model with a queue of expected beats,
// per-cycle output compare, and directed scenarios with literal expectations.
module tb_lane_mem_ctrl;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 16;
    localparam int LEN_W  = 4;
    localparam int DW     = LANES * LANE_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic [DW-1:0]     req_wdata;
    logic [LANES-1:0]  req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DW-1:0]     rsp_data;
    logic              rsp_last;
    logic              rsp_err;

    always #5 clk = ~clk;

    lane_mem_ctrl #(
        .LANES(LANES), .LANE_W(LANE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_err(rsp_err)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic          e;
    } beat_t;

    int          checks = 0;
    int          errors = 0;
    logic        chk_en = 1'b0;
    logic [DW-1:0] mmem [DEPTH];
    beat_t       exp_q[$];
    beat_t       cap_q[$];
    logic        tog_en = 1'b0;
    int          tog_i  = 0;
    logic [3:0]  tog_pat = 4'b1001;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: an empty expectation queue means the block is free to accept.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (exp_q.size() != 0) begin
            if (rsp_ready) void'(exp_q.pop_front());
        end else if (req_valid) begin
            if (req_write) begin
                if (req_addr < DEPTH) begin
                    for (int i = 0; i < LANES; i++)
                        if (req_be[i]) mmem[req_addr][i*LANE_W +: LANE_W] = req_wdata[i*LANE_W +: LANE_W];
                end
                exp_q.push_back('{d: '0, l: 1'b1, e: (req_addr >= DEPTH)});
            end else begin
                for (int k = 0; k <= int'(req_len); k++) begin
                    logic [ADDR_W-1:0] a;
                    a = req_addr + ADDR_W'(k);
                    if (a < DEPTH) exp_q.push_back('{d: mmem[a], l: (k == int'(req_len)), e: 1'b0});
                    else           exp_q.push_back('{d: '0, l: (k == int'(req_len)), e: 1'b1});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() != 0) begin
                chk("req_ready", req_ready, 0);
                chk("rsp_valid", rsp_valid, 1);
                chk("rsp_data", rsp_data, exp_q[0].d);
                chk("rsp_last", rsp_last, exp_q[0].l);
                chk("rsp_err", rsp_err, exp_q[0].e);
            end else begin
                chk("req_ready_idle", req_ready, 1);
                chk("rsp_valid_idle", rsp_valid, 0);
                chk("rsp_data_idle", rsp_data, 0);
                chk("rsp_last_idle", rsp_last, 0);
                chk("rsp_err_idle", rsp_err, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rsp_valid && rsp_ready) cap_q.push_back('{d: rsp_data, l: rsp_last, e: rsp_err});
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tog_en) begin
                rsp_ready = tog_pat[3 - tog_i];
                tog_i = (tog_i + 1) % 4;
            end
        end
    end

    task automatic send(input logic w, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                        input logic [DW-1:0] d, input logic [LANES-1:0] b);
        logic ok;
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_write = w; req_addr = a; req_len = l; req_wdata = d; req_be = b;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) chk("drain_timeout", 0, 1);
    endtask

    task automatic chk_burst(input string name, input int n, input logic [ADDR_W-1:0] a0);
        chk({name, "_count"}, cap_q.size(), n);
        for (int k = 0; k < n && k < cap_q.size(); k++) begin
            logic [ADDR_W-1:0] a;
            a = a0 + ADDR_W'(k);
            chk({name, "_data"}, cap_q[k].d, (a < DEPTH) ? DW'(a) * 32'h01010101 : 32'h0);
            chk({name, "_err"}, cap_q[k].e, (a >= DEPTH));
            chk({name, "_last"}, cap_q[k].l, (k == n - 1));
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
        rst = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = '0; req_len = '0;
        req_wdata = '0; req_be = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        @(posedge clk);
        #1; rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("no_accept_in_rst", rsp_valid, 0);

        send(1'b1, 16'd3, 4'd0, 32'hDEADBEEF, 4'b1111); drain();
        send(1'b1, 16'd3, 4'd0, 32'h11223344, 4'b0101); drain();
        chk("model_merge", mmem[3], 32'hDE22BE44);
        send(1'b0, 16'd3, 4'd0, 32'h0, 4'b0);
        @(negedge clk);
        chk("merge_valid", rsp_valid, 1);
        chk("merge_data", rsp_data, 32'hDE22BE44);
        chk("merge_last", rsp_last, 1);
        chk("merge_err", rsp_err, 0);
        drain();

        for (int a = 0; a < DEPTH; a++) begin
            send(1'b1, ADDR_W'(a), 4'd0, DW'(a) * 32'h01010101, 4'b1111);
            drain();
        end

        cap_q.delete();
        send(1'b0, 16'd12, 4'd5, 32'h0, 4'b0); drain();
        chk_burst("burst12", 6, 16'd12);
        chk("burst12_beat0", cap_q.size() > 0 ? cap_q[0].d : 32'hX, 32'h0C0C0C0C);

        cap_q.delete();
        tog_i = 0; tog_en = 1'b1;
        send(1'b0, 16'd12, 4'd5, 32'h0, 4'b0); drain();
        tog_en = 1'b0;
        @(posedge clk); #1 rsp_ready = 1'b1;
        chk_burst("stall12", 6, 16'd12);

        send(1'b1, 16'd16, 4'd0, 32'hFFFFFFFF, 4'b1111);
        @(negedge clk);
        chk("oob_wr_valid", rsp_valid, 1);
        chk("oob_wr_err", rsp_err, 1);
        chk("oob_wr_data", rsp_data, 0);
        drain();
        cap_q.delete();
        send(1'b0, 16'd0, 4'd15, 32'h0, 4'b0); drain();
        chk_burst("full_read", 16, 16'd0);

        cap_q.delete();
        send(1'b0, 16'hFFFF, 4'd2, 32'h0, 4'b0); drain();
        chk_burst("wrap", 3, 16'hFFFF);

        cap_q.delete();
        send(1'b0, 16'd0, 4'd7, 32'h0, 4'b0);
        for (int i = 0; i < 50; i++) begin
            if (cap_q.size() >= 2) break;
            @(negedge clk);
        end
        chk("midrst_beats_seen", cap_q.size(), 2);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_req_ready", req_ready, 1);
        send(1'b0, 16'd0, 4'd0, 32'h0, 4'b0);
        @(negedge clk);
        chk("post_rst_rd0", rsp_data, 32'h00000000);
        chk("post_rst_rd0_last", rsp_last, 1);
        drain();
        send(1'b0, 16'd5, 4'd0, 32'h0, 4'b0);
        @(negedge clk);
        chk("post_rst_rd5", rsp_data, 32'h05050505);
        drain();

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
